// File: rtl/reorder_buf_pkg.sv
// Shared ROB types, widths and the circular index increment.
package reorder_buf_pkg;

    localparam int unsigned ROB_SIZE   = 16;
    localparam int unsigned ROB_IDX_LN = $clog2(ROB_SIZE);
    localparam int unsigned REG_IDX_LN = 5;
    localparam int unsigned WORD_LN    = 32;

    typedef logic [ROB_IDX_LN-1:0] ROB_IDX_TP;
    typedef logic [REG_IDX_LN-1:0] REG_IDX_TP;
    typedef logic [WORD_LN-1:0]    WORD_TP;

    // Index 0 means "no producer" and is never handed out.
    localparam ROB_IDX_TP ZERO_ROB_IDX = '0;

    // Advance a ROB index, wrapping from size-1 back to 1 (skipping 0).
    function automatic ROB_IDX_TP rob_idx_inc(input ROB_IDX_TP idx, input int unsigned size);
        return (idx == ROB_IDX_TP'(size - 1)) ? ROB_IDX_TP'(1) : idx + ROB_IDX_TP'(1);
    endfunction

endpackage

// File: rtl/reorder_buf_if.sv
// Decode/CDB/commit bus of the reorder buffer.
interface reorder_buf_if;
    import reorder_buf_pkg::*;

    logic      rdy;
    logic      id_alloc_ena;
    REG_IDX_TP id_alloc_rd;
    logic      id_alloc_is_br;
    logic      id_alloc_is_st;
    logic      rob_full;
    ROB_IDX_TP rob_next_idx;
    logic      cdb_ena;
    ROB_IDX_TP cdb_idx;
    WORD_TP    cdb_val;
    logic      cdb_mispred;
    WORD_TP    cdb_target;
    ROB_IDX_TP qry_idx1;
    ROB_IDX_TP qry_idx2;
    logic      qry_rdy1;
    logic      qry_rdy2;
    WORD_TP    qry_val1;
    WORD_TP    qry_val2;
    logic      rob_wr_ena;
    REG_IDX_TP rob_wr_rd;
    WORD_TP    rob_wr_val;
    ROB_IDX_TP rob_wr_idx;
    logic      st_commit_ena;
    ROB_IDX_TP st_commit_idx;
    logic      reg_rb;
    WORD_TP    rb_pc;

    modport master (
        output rdy, id_alloc_ena, id_alloc_rd, id_alloc_is_br, id_alloc_is_st,
               cdb_ena, cdb_idx, cdb_val, cdb_mispred, cdb_target, qry_idx1, qry_idx2,
        input  rob_full, rob_next_idx, qry_rdy1, qry_rdy2, qry_val1, qry_val2,
               rob_wr_ena, rob_wr_rd, rob_wr_val, rob_wr_idx, st_commit_ena,
               st_commit_idx, reg_rb, rb_pc
    );

    modport slave (
        input  rdy, id_alloc_ena, id_alloc_rd, id_alloc_is_br, id_alloc_is_st,
               cdb_ena, cdb_idx, cdb_val, cdb_mispred, cdb_target, qry_idx1, qry_idx2,
        output rob_full, rob_next_idx, qry_rdy1, qry_rdy2, qry_val1, qry_val2,
               rob_wr_ena, rob_wr_rd, rob_wr_val, rob_wr_idx, st_commit_ena,
               st_commit_idx, reg_rb, rb_pc
    );

endinterface

// File: rtl/reorder_buf.sv
// Circular reorder buffer: in-order allocate, out-of-order writeback,
// in-order commit with branch-mispredict rollback.
module reorder_buf #(
    parameter int unsigned ROB_SIZE = reorder_buf_pkg::ROB_SIZE
) (
    input logic          clk,
    input logic          rst,
    reorder_buf_if.slave bus
);
    import reorder_buf_pkg::*;

    localparam int unsigned ROB_DEPTH = 1 << ROB_IDX_LN;

    logic [ROB_DEPTH-1:0] valid_q;
    logic [ROB_DEPTH-1:0] ready_q;
    logic [ROB_DEPTH-1:0] is_br_q;
    logic [ROB_DEPTH-1:0] is_st_q;
    logic [ROB_DEPTH-1:0] mispred_q;
    REG_IDX_TP            rd_q     [ROB_DEPTH];
    WORD_TP               val_q    [ROB_DEPTH];
    WORD_TP               target_q [ROB_DEPTH];
    ROB_IDX_TP            head_q;
    ROB_IDX_TP            tail_q;
    ROB_IDX_TP            count_q;

    logic      full_c;
    logic      commit_c;
    logic      flush_c;
    logic      alloc_c;
    logic      wb_c;
    logic      qry_rdy1_c;
    logic      qry_rdy2_c;
    WORD_TP    qry_val1_c;
    WORD_TP    qry_val2_c;

    // Per-cycle control decisions.
    assign full_c   = (count_q == ROB_IDX_TP'(ROB_SIZE - 1));
    assign commit_c = bus.rdy && valid_q[head_q] && ready_q[head_q];
    assign flush_c  = commit_c && mispred_q[head_q];
    assign alloc_c  = bus.rdy && bus.id_alloc_ena && !full_c && !flush_c;
    assign wb_c     = bus.rdy && bus.cdb_ena && !flush_c &&
                      (bus.cdb_idx != ZERO_ROB_IDX) && valid_q[bus.cdb_idx];

    // Pointers, occupancy and per-entry status bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            ready_q <= '0;
            head_q  <= ROB_IDX_TP'(1);
            tail_q  <= ROB_IDX_TP'(1);
            count_q <= '0;
        end else if (flush_c) begin
            valid_q <= '0;
            ready_q <= '0;
            head_q  <= ROB_IDX_TP'(1);
            tail_q  <= ROB_IDX_TP'(1);
            count_q <= '0;
        end else begin
            if (commit_c) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= rob_idx_inc(head_q, ROB_SIZE);
            end
            if (wb_c) begin
                ready_q[bus.cdb_idx] <= 1'b1;
            end
            if (alloc_c) begin
                valid_q[tail_q] <= 1'b1;
                ready_q[tail_q] <= 1'b0;
                tail_q          <= rob_idx_inc(tail_q, ROB_SIZE);
            end
            case ({alloc_c, commit_c})
                2'b10:   count_q <= count_q + ROB_IDX_TP'(1);
                2'b01:   count_q <= count_q - ROB_IDX_TP'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry payload; qualified by valid so it needs no reset.
    always_ff @(posedge clk) begin
        if (alloc_c) begin
            rd_q[tail_q]      <= bus.id_alloc_rd;
            is_br_q[tail_q]   <= bus.id_alloc_is_br;
            is_st_q[tail_q]   <= bus.id_alloc_is_st;
            mispred_q[tail_q] <= 1'b0;
        end
        if (wb_c) begin
            val_q[bus.cdb_idx]     <= bus.cdb_val;
            target_q[bus.cdb_idx]  <= bus.cdb_target;
            // Only control-flow entries can redirect fetch.
            mispred_q[bus.cdb_idx] <= bus.cdb_mispred && is_br_q[bus.cdb_idx];
        end
    end

    // Operand lookup with same-cycle CDB bypass taking priority.
    always_comb begin
        qry_rdy1_c = 1'b0;
        qry_val1_c = '0;
        qry_rdy2_c = 1'b0;
        qry_val2_c = '0;
        if (rst && bus.qry_idx1 != ZERO_ROB_IDX) begin
            if (bus.cdb_ena && bus.cdb_idx == bus.qry_idx1) begin
                qry_rdy1_c = 1'b1;
                qry_val1_c = bus.cdb_val;
            end else if (valid_q[bus.qry_idx1] && ready_q[bus.qry_idx1]) begin
                qry_rdy1_c = 1'b1;
                qry_val1_c = val_q[bus.qry_idx1];
            end
        end
        if (rst && bus.qry_idx2 != ZERO_ROB_IDX) begin
            if (bus.cdb_ena && bus.cdb_idx == bus.qry_idx2) begin
                qry_rdy2_c = 1'b1;
                qry_val2_c = bus.cdb_val;
            end else if (valid_q[bus.qry_idx2] && ready_q[bus.qry_idx2]) begin
                qry_rdy2_c = 1'b1;
                qry_val2_c = val_q[bus.qry_idx2];
            end
        end
    end

    // Outputs: commit fields are driven only while the head is retiring.
    assign bus.rob_full      = full_c;
    assign bus.rob_next_idx  = tail_q;
    assign bus.qry_rdy1      = qry_rdy1_c;
    assign bus.qry_val1      = qry_val1_c;
    assign bus.qry_rdy2      = qry_rdy2_c;
    assign bus.qry_val2      = qry_val2_c;
    assign bus.rob_wr_ena    = commit_c && (rd_q[head_q] != '0);
    assign bus.rob_wr_rd     = commit_c ? rd_q[head_q] : '0;
    assign bus.rob_wr_val    = commit_c ? val_q[head_q] : '0;
    assign bus.rob_wr_idx    = commit_c ? head_q : '0;
    assign bus.st_commit_ena = commit_c && is_st_q[head_q];
    assign bus.st_commit_idx = (commit_c && is_st_q[head_q]) ? head_q : '0;
    assign bus.reg_rb        = flush_c;
    assign bus.rb_pc         = flush_c ? target_q[head_q] : '0;

endmodule
